// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with little-endian byte lanes,
// programmable wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter logic [31:0] START_ADDR     = 32'h0,
  parameter logic [31:0] DEPTH_IN_BYTES = 32'h100,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYOUT
);

  localparam logic [31:0] END_ADDR =
    START_ADDR + DEPTH_IN_BYTES - 32'd1;
  localparam int NW = int'(DEPTH_IN_BYTES >> 2);
  localparam int IW = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;
  logic           r_act;
  logic           w_act_nxt;
  logic           r_write;
  logic [3:0]     r_be;
  logic [IW-1:0]  r_idx;
  logic [31:0]    r_mem [NW];

  logic [32:0]    w_diff;
  logic           w_range_err;
  logic           w_size_err;
  logic           w_align_err;
  logic           w_err;
  logic [3:0]     w_be;
  logic           w_ready;
  logic           w_accept;
  logic           w_done;
  logic           w_unused;

  assign w_diff = {1'b0, HADDR} - {1'b0, START_ADDR};
  assign w_range_err = w_diff[32] | (HADDR > END_ADDR);
  assign w_unused = ^{HBURST, w_diff[31:IW+2]};

  always_comb begin
    w_be        = 4'b0000;
    w_size_err  = 1'b0;
    w_align_err = 1'b0;
    unique case (HSIZE)
      3'd0: w_be = 4'b0001 << HADDR[1:0];
      3'd1: begin
        w_align_err = HADDR[0];
        w_be = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        w_align_err = |HADDR[1:0];
        w_be = 4'b1111;
      end
      default: w_size_err = 1'b1;
    endcase
  end

  assign w_err = w_range_err | w_size_err | w_align_err;
  assign w_ready = (r_state == S_IDLE) | (r_state == S_ERR2);
  assign w_accept = w_ready & HSEL & HREADY & HTRANS[1];
  // An IDLE state with a live data phase is the completing cycle.
  assign w_done = (r_state == S_IDLE) & r_act;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_act_nxt   = r_act;
    unique case (r_state)
      S_IDLE, S_ERR2: begin
        w_state_nxt = S_IDLE;
        w_act_nxt   = 1'b0;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = S_ERR1;
          end else begin
            w_act_nxt = 1'b1;
            if (WAIT_STATES > 0) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else w_cnt_nxt = r_cnt - 4'd1;
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_act   <= 1'b0;
      r_write <= 1'b0;
      r_be    <= 4'b0000;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_act   <= w_act_nxt;
      if (w_accept) begin
        r_write <= HWRITE;
        r_be    <= w_be;
        r_idx   <= w_diff[IW+1:2];
      end
    end
  end

  // Array is not reset; a reset between edges also kills r_act.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_done && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = w_ready;
  assign HRESP = ((r_state == S_ERR1) | (r_state == S_ERR2)) ?
                 2'b01 : 2'b00;
  assign HRDATA = (w_done & ~r_write) ? r_mem[r_idx] : 32'h0;

endmodule
